// File: rtl/minv_v_seq_if.sv
// Handshake bundle between the upper layer and the V-register sequencer:
// command port, load word stream and readout word stream.
interface minv_v_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  modport master (
    output cmd_valid, cmd_op, in_valid, in_data, out_ready,
    input  cmd_ready, in_ready, out_valid, out_data
  );

  modport slave (
    input  cmd_valid, cmd_op, in_valid, in_data, out_ready,
    output cmd_ready, in_ready, out_valid, out_data
  );
endinterface

// File: rtl/minv_v_seq.sv
// Sequencer for the 256-bit V register of the modular-inverse datapath.
// Optional zero-operand scan before STRIP: define MINV_VSEQ_ZERO_DET_EN.
module minv_v_seq #(
  parameter int unsigned NWORDS = 8,
  parameter int unsigned CNT_W  = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  minv_v_seq_if.slave      bus,
  input  logic [31:0]      reg_lsw,
  output logic [31:0]      reg_regin,
  output logic             reg_we,
  output logic             reg_sel_cyc,
  output logic             reg_sel_rs,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             done,
  output logic             err
);

  localparam int unsigned WCNT_W = $clog2(NWORDS + 1);
  localparam int unsigned NBITS  = NWORDS * 32;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_STRIP = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_HALVE = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_STRIP = 3'd2,
    S_READ  = 3'd3,
    S_HALVE = 3'd4,
    S_DONE  = 3'd5,
    S_SCAN  = 3'd6
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WCNT_W-1:0]  r_word_cnt;
  logic [CNT_W-1:0]   r_shift_cnt;
  logic               w_accept;
  logic               w_in_hs;
  logic               w_out_hs;
  logic               w_scan;
  logic               w_last_word;
  logic               w_can_shift;

  assign w_accept    = (r_state == S_IDLE) && bus.cmd_valid;
  assign w_in_hs     = (r_state == S_LOAD) && bus.in_valid;
  assign w_out_hs    = (r_state == S_READ) && bus.out_ready;
  assign w_scan      = (r_state == S_SCAN);
  assign w_last_word = (r_word_cnt == WCNT_W'(NWORDS - 1));
  assign w_can_shift = !reg_lsw[0] && (r_shift_cnt < CNT_W'(NBITS));

  assign reg_regin    = bus.in_data;
  assign bus.out_data = reg_lsw;
  assign shift_cnt    = r_shift_cnt;

`ifdef MINV_VSEQ_ZERO_DET_EN
  logic r_nz;
  logic r_err;
  logic w_any_nz;

  // Running OR of every word seen while the scan rotates the register once.
  assign w_any_nz = r_nz | (|reg_lsw);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nz  <= 1'b0;
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_nz  <= 1'b0;
      r_err <= 1'b0;
    end else if (w_scan) begin
      r_nz <= w_any_nz;
      if (w_last_word && !w_any_nz) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            OP_LOAD:  w_next = S_LOAD;
`ifdef MINV_VSEQ_ZERO_DET_EN
            OP_STRIP: w_next = S_SCAN;
`else
            OP_STRIP: w_next = S_STRIP;
`endif
            OP_READ:  w_next = S_READ;
            OP_HALVE: w_next = S_HALVE;
            default:  w_next = S_IDLE;
          endcase
        end
      end
      S_LOAD: begin
        if (w_in_hs && w_last_word) begin
          w_next = S_DONE;
        end
      end
      S_READ: begin
        if (w_out_hs && w_last_word) begin
          w_next = S_DONE;
        end
      end
      S_STRIP: begin
        if (!w_can_shift) begin
          w_next = S_DONE;
        end
      end
`ifdef MINV_VSEQ_ZERO_DET_EN
      S_SCAN: begin
        if (w_last_word) begin
          w_next = w_any_nz ? S_STRIP : S_DONE;
        end
      end
`endif
      S_HALVE: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Register strobes and handshake outputs; strobes coincide with the capture edge
  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    reg_we        = 1'b0;
    reg_sel_cyc   = 1'b0;
    reg_sel_rs    = 1'b0;
    done          = 1'b0;
    case (r_state)
      S_IDLE: bus.cmd_ready = 1'b1;
      S_LOAD: begin
        bus.in_ready = 1'b1;
        reg_we       = w_in_hs;
      end
      S_READ: begin
        bus.out_valid = 1'b1;
        reg_we        = w_out_hs;
        reg_sel_cyc   = w_out_hs;
      end
      S_STRIP: begin
        reg_we     = w_can_shift;
        reg_sel_rs = w_can_shift;
      end
      S_SCAN: begin
        reg_we      = 1'b1;
        reg_sel_cyc = 1'b1;
      end
      S_HALVE: begin
        reg_we     = 1'b1;
        reg_sel_rs = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Word counter serves LOAD, READ and SCAN; shift counter only advances in STRIP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_cnt  <= '0;
      r_shift_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_word_cnt <= '0;
        if (bus.cmd_op == OP_STRIP) begin
          r_shift_cnt <= '0;
        end
      end else if (w_in_hs || w_out_hs || w_scan) begin
        r_word_cnt <= r_word_cnt + WCNT_W'(1);
      end
      if ((r_state == S_STRIP) && w_can_shift) begin
        r_shift_cnt <= r_shift_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_minv_v_seq.sv
// Bench for minv_v_seq: behavioural V register plus arithmetic reference.
module tb_minv_v_seq;
  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_STRIP = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_HALVE = 2'd3;
`ifdef MINV_VSEQ_ZERO_DET_EN
  localparam bit ZDET = 1'b1;
`else
  localparam bit ZDET = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  minv_v_seq_if bus();
  logic [31:0]  reg_lsw;
  logic [31:0]  reg_regin;
  logic         reg_we, reg_sel_cyc, reg_sel_rs, done, err;
  logic [8:0]   shift_cnt;
  logic [255:0] v_reg = '0;

  // The 256-bit V register being sequenced
  always @(posedge clk) begin
    if (reg_we) begin
      if (reg_sel_rs)       v_reg <= v_reg >> 1;
      else if (reg_sel_cyc) v_reg <= {v_reg[31:0], v_reg[255:32]};
      else                  v_reg <= {reg_regin, v_reg[255:32]};
    end
  end
  assign reg_lsw = v_reg[31:0];

  minv_v_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .reg_lsw     (reg_lsw),
    .reg_regin   (reg_regin),
    .reg_we      (reg_we),
    .reg_sel_cyc (reg_sel_cyc),
    .reg_sel_rs  (reg_sel_rs),
    .shift_cnt   (shift_cnt),
    .done        (done),
    .err         (err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int           n_we, n_cyc, n_rs, n_bad, n_hold_bad, done_cyc;
  bit           done_seen;
  logic         err_at_done;
  logic [255:0] rd_val;

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int ctz(input logic [255:0] v);
    for (int i = 0; i < 256; i++) if (v[i]) return i;
    return 256;
  endfunction

  // Issue one command and drive its data phase until done; mode 0=always ready, 1=random, 2=toggle
  task automatic run_op(input logic [1:0] op, input logic [255:0] val, input int mode);
    int idx, ridx, cyc;
    bit tog, stalled;
    logic [31:0] held;
    idx = 0; ridx = 0; cyc = 0; tog = 1'b0; stalled = 1'b0; held = '0;
    n_we = 0; n_cyc = 0; n_rs = 0; n_bad = 0; n_hold_bad = 0; done_cyc = 0;
    done_seen = 1'b0; err_at_done = 1'b0; rd_val = '0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    while (!done_seen && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      bus.in_valid = (op == OP_LOAD) && (idx < 8) && ((mode == 0) || ($urandom_range(0, 2) != 0));
      bus.in_data  = (idx < 8) ? val[idx*32 +: 32] : $urandom;
      tog = ~tog;
      bus.out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : tog;
      #1;
      if (reg_we)      n_we++;
      if (reg_sel_cyc) n_cyc++;
      if (reg_sel_rs)  n_rs++;
      if ((reg_sel_cyc && reg_sel_rs) || ((reg_sel_cyc || reg_sel_rs) && !reg_we)) n_bad++;
      if (stalled && bus.out_data !== held) n_hold_bad++;
      stalled = bus.out_valid && !bus.out_ready;
      held    = bus.out_data;
      if (bus.in_valid && bus.in_ready) idx++;
      if (bus.out_valid && bus.out_ready) begin
        if (ridx < 8) rd_val[ridx*32 +: 32] = bus.out_data;
        ridx++;
      end
      if (done) begin
        done_seen   = 1'b1;
        done_cyc    = cyc;
        err_at_done = err;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({bus.cmd_ready, bus.in_ready, bus.out_valid, reg_we, reg_sel_cyc, reg_sel_rs, done, err} !== 8'b1000_0000)
      $display("FAIL reset_outputs got=%b exp=%b",
               {bus.cmd_ready, bus.in_ready, bus.out_valid, reg_we, reg_sel_cyc, reg_sel_rs, done, err}, 8'b1000_0000);
    else n_pass++;
    n_checks++;
    if (shift_cnt !== 9'd0) $display("FAIL reset_shift_cnt got=%0d exp=0", shift_cnt);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_read(input logic [255:0] val, input int load_mode, input int read_mode);
    run_op(OP_LOAD, val, load_mode);
    n_checks++;
    if (!done_seen || n_we != 8 || n_cyc != 0 || n_rs != 0 || n_bad != 0)
      $display("FAIL load_strobes done=%0d we=%0d cyc=%0d rs=%0d bad=%0d exp done=1 we=8 cyc=0 rs=0 bad=0",
               done_seen, n_we, n_cyc, n_rs, n_bad);
    else n_pass++;
    run_op(OP_READ, '0, read_mode);
    n_checks++;
    if (!done_seen || n_cyc != 8 || n_we != 8 || n_rs != 0 || n_hold_bad != 0)
      $display("FAIL read_strobes done=%0d cyc=%0d we=%0d rs=%0d holdbad=%0d exp 1/8/8/0/0",
               done_seen, n_cyc, n_we, n_rs, n_hold_bad);
    else n_pass++;
    n_checks++;
    if (rd_val !== val) $display("FAIL read_data got=%h exp=%h", rd_val, val);
    else n_pass++;
  endtask

  task automatic test_strip(input logic [255:0] val);
    int k;
    k = ctz(val);
    run_op(OP_LOAD, val, 1);
    run_op(OP_STRIP, '0, 0);
    n_checks++;
    if (!done_seen || shift_cnt !== 9'(k) || n_rs != k || err_at_done !== 1'b0)
      $display("FAIL strip_count done=%0d shift_cnt=%0d rs=%0d err=%b exp shift=%0d err=0",
               done_seen, shift_cnt, n_rs, err_at_done, k);
    else n_pass++;
    run_op(OP_READ, '0, 1);
    n_checks++;
    if (rd_val !== (val >> k)) $display("FAIL strip_value got=%h exp=%h", rd_val, val >> k);
    else n_pass++;
  endtask

  task automatic test_strip_odd();
    run_op(OP_LOAD, 256'h7, 0);
    run_op(OP_STRIP, '0, 0);
    n_checks++;
    if (!done_seen || done_cyc != (ZDET ? 10 : 2) || n_rs != 0 || n_we != (ZDET ? 8 : 0) || shift_cnt !== 9'd0)
      $display("FAIL strip_odd done=%0d lat=%0d rs=%0d we=%0d shift=%0d exp lat=%0d rs=0 we=%0d shift=0",
               done_seen, done_cyc, n_rs, n_we, shift_cnt, ZDET ? 10 : 2, ZDET ? 8 : 0);
    else n_pass++;
  endtask

  task automatic test_halve();
    logic [255:0] val;
    logic [8:0]   sc;
    val = rand256();
    sc  = shift_cnt;
    run_op(OP_LOAD, val, 1);
    run_op(OP_HALVE, '0, 0);
    n_checks++;
    if (!done_seen || done_cyc != 2 || n_rs != 1 || n_we != 1 || shift_cnt !== sc)
      $display("FAIL halve_strobes done=%0d lat=%0d rs=%0d we=%0d shift=%0d exp lat=2 rs=1 we=1 shift=%0d",
               done_seen, done_cyc, n_rs, n_we, shift_cnt, sc);
    else n_pass++;
    run_op(OP_READ, '0, 0);
    n_checks++;
    if (rd_val !== (val >> 1)) $display("FAIL halve_value got=%h exp=%h", rd_val, val >> 1);
    else n_pass++;
  endtask

  task automatic test_read_twice();
    logic [255:0] val, first;
    val = rand256();
    run_op(OP_LOAD, val, 0);
    run_op(OP_READ, '0, 2);
    first = rd_val;
    n_checks++;
    if (!done_seen || n_cyc != 8 || n_hold_bad != 0 || first !== val)
      $display("FAIL read_toggle1 done=%0d cyc=%0d holdbad=%0d got=%h exp=%h", done_seen, n_cyc, n_hold_bad, first, val);
    else n_pass++;
    run_op(OP_READ, '0, 2);
    n_checks++;
    if (!done_seen || n_cyc != 8 || rd_val !== first)
      $display("FAIL read_toggle2 done=%0d cyc=%0d got=%h exp=%h", done_seen, n_cyc, rd_val, first);
    else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_LOAD;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'(k + 1);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.cmd_ready, bus.in_ready, bus.out_valid, reg_we, reg_sel_cyc, reg_sel_rs, done, err} !== 8'b1000_0000)
      $display("FAIL midload_reset got=%b exp=%b",
               {bus.cmd_ready, bus.in_ready, bus.out_valid, reg_we, reg_sel_cyc, reg_sel_rs, done, err}, 8'b1000_0000);
    else n_pass++;
    n_checks++;
    if (shift_cnt !== 9'd0) $display("FAIL midload_shift_cnt got=%0d exp=0", shift_cnt);
    else n_pass++;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.cmd_ready !== 1'b1 || bus.in_ready !== 1'b0) $display("FAIL midload_release cmd_ready=%b in_ready=%b exp 1 0",
                                                                bus.cmd_ready, bus.in_ready);
    else n_pass++;
  endtask

  task automatic test_zero_strip();
    run_op(OP_LOAD, '0, 1);
    run_op(OP_STRIP, '0, 0);
    n_checks++;
    if (!done_seen || shift_cnt !== (ZDET ? 9'd0 : 9'd256) || err_at_done !== ZDET ||
        n_rs != (ZDET ? 0 : 256) || n_cyc != (ZDET ? 8 : 0))
      $display("FAIL zero_strip done=%0d shift=%0d err=%b rs=%0d cyc=%0d exp shift=%0d err=%b rs=%0d cyc=%0d",
               done_seen, shift_cnt, err_at_done, n_rs, n_cyc, ZDET ? 0 : 256, ZDET, ZDET ? 0 : 256, ZDET ? 8 : 0);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (err !== ZDET) $display("FAIL zero_err_hold got=%b exp=%b", err, ZDET);
    else n_pass++;
    run_op(OP_READ, '0, 0);
    n_checks++;
    if (err !== 1'b0 || rd_val !== '0) $display("FAIL zero_after err=%b val=%h exp err=0 val=0", err, rd_val);
    else n_pass++;
  endtask

  initial begin
    logic [255:0] seq;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_LOAD;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) seq[i*32 +: 32] = 32'(i + 1);

    test_reset();
    test_load_read(seq, 1, 0);
    for (int i = 0; i < 3; i++) test_load_read(rand256(), 1, 1);
    test_strip(256'h28);
    for (int i = 0; i < 3; i++) test_strip((rand256() | 256'h1) << $urandom_range(1, 40));
    test_strip(256'h1 << 200);
    test_strip_odd();
    test_halve();
    test_read_twice();
    test_reset_mid_load();
    test_zero_strip();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/minv_v_seq.md
Name: minv_v_seq

Overview:
- Sequencer directly upstream of the 256-bit V register of the modular-inverse datapath.
- Converts a 32-bit word stream and simple commands into the register's control strobes: regin, we, sel_cyc and sel_rs.
- Operations: load the register, strip trailing zeros (binary-inverse halving loop), single halve, and non-destructive readout by cyclic rotation.
- Only `reg_lsw` (register bits [31:0]) is fed back from the register.

Parameters:
- NWORDS, 8, number of 32-bit words in the register (256/32).
- CNT_W, 9, width of shift counter; must hold NWORDS*32.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  0=LOAD, 1=STRIP, 2=READ, 3=HALVE.
- in_valid  in  1  load word valid.
- in_ready  out  1  high only in LOAD.
- in_data  in  32  load word; least-significant word first.
- out_valid  out  1  high only in READ.
- out_ready  in  1  readout consumer ready.
- out_data  out  32  equals reg_lsw.
- reg_lsw  in  32  register bits [31:0].
- reg_regin  out  32  to register regin; equals in_data.
- reg_we  out  1  register write enable.
- reg_sel_cyc  out  1  1 = rotate right 32 bits.
- reg_sel_rs  out  1  1 = shift right 1 bit.
- shift_cnt  out  CNT_W  number of 1-bit shifts performed by the last STRIP.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  zero operand flagged; only exists with the feature macro.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE; word counter=0; shift_cnt=0.
  - done=0, err=0, reg_we=0, reg_sel_cyc=0, reg_sel_rs=0.
  - in_ready=0, out_valid=0, cmd_ready=1.
- Reset mid-operation aborts the operation. The register content is then undefined and the upper layer must issue LOAD again.
- Strobe outputs are combinational from state and handshakes. The register captures at the same edge as the handshake.
- States: IDLE, LOAD, STRIP, READ, HALVE, DONE.
- IDLE: on cmd_valid, latch cmd_op and go to the state for that op. Word counter and shift_cnt clear on entry to LOAD and STRIP respectively. In all other states cmd_valid is ignored.
- LOAD:
  - Each in_valid&&in_ready cycle drives reg_we=1, sel_cyc=0, sel_rs=0 (shift-in to top, right shift by 32) and increments the word counter.
  - After NWORDS handshakes → DONE. The first word ends at bits [31:0].
  - in_valid low means stall with no strobes.
- STRIP:
  - Each cycle with reg_lsw[0]==0 and shift_cnt<NWORDS*32: reg_we=1, sel_rs=1, shift_cnt++.
  - Otherwise → DONE with no strobe.
  - Minimum latency is 2 cycles (odd operand, shift_cnt=0).
  - Without the feature, an all-zero register stops at shift_cnt=256.
- HALVE: one cycle with reg_we=1, sel_rs=1 → DONE. shift_cnt is unchanged.
- READ:
  - out_valid=1 and out_data=reg_lsw.
  - Each out_valid&&out_ready drives reg_we=1, sel_cyc=1 (rotate) and increments the word counter.
  - After NWORDS handshakes the register is restored → DONE.
  - out_ready low means stall and out_data holds.
- DONE: done=1 for one cycle → IDLE.
- Only one of sel_cyc/sel_rs is ever high. Strobes are never asserted outside the listed cases.

Optional Feature:
- Macro: MINV_VSEQ_ZERO_DET_EN.
- With the macro, STRIP first runs a SCAN state:
  - NWORDS rotate cycles (reg_we=1, sel_cyc=1), ORing reg_lsw into a flag; the register is restored after the scan.
  - All zero: → DONE with err=1 and shift_cnt=0, and no shift is performed.
  - Otherwise: normal strip proceeds, err=0.
  - STRIP latency grows by NWORDS.
- err is valid with done and holds until the next command is accepted.
- Without the macro: no SCAN state, err is tied 0, and an all-zero strip gives shift_cnt=256.

Test Plan:
- LOAD of words 0x1..0x8 with in_valid gaps → exactly 8 we pulses with sel_cyc=0; READ then returns 0x1..0x8 in order, then done.
- LOAD of value 0x28 (word0=0x28, other words 0), STRIP → 3 sel_rs pulses, shift_cnt=3; READ word0=0x5.
- STRIP on odd value 0x7 → no strobes, done 2 cycles after command accepted, shift_cnt=0.
- READ with out_ready toggling every other cycle → exactly 8 rotations; second READ yields identical words.
- Assert rst_n low during LOAD after 3 words → all outputs at reset values immediately; cmd_ready=1 after release.
- All-zero load then STRIP → with macro: 8 rotations, err=1, shift_cnt=0; without macro: shift_cnt=256, err=0.
